// File: rtl/uart_probe.sv
// Byte-command debug probe: UART byte stream in/out, GPI/GPO access and a
// single-beat AXI4-Lite-style master driven through address/control registers.
module uart_probe (
  input  logic        clk,
  input  logic        m_aresetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [31:0] gpo,
  input  logic [31:0] gpi,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arsize,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awsize,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  typedef enum logic [2:0] {S_IDLE, S_ARG, S_TX, S_AR, S_R, S_AW, S_B} state_t;

  state_t      state_q;
  logic [7:0]  cmd_q, tx_data_q;
  logic [31:0] gpo_q, addr_q, rdata_q, wdata_q;
  logic [2:0]  size_q;
  logic [1:0]  resp_q, tx_cnt_q, tx_idx_q;
  logic [3:0]  wstrb_q;
  logic        rx_ready_q, tx_valid_q, arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] n);
    case (n)
      2'd0:    byte_sel = w[7:0];
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      default: byte_sel = w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] byte_put(input logic [31:0] w, input logic [1:0] n,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (n)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] strb_for(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    strb_for = 4'b0001 << a;
      3'd1:    strb_for = 4'b0011 << {a[1], 1'b0};
      default: strb_for = 4'hF;
    endcase
  endfunction

  // Every per-byte command range starts at a code that is 2 mod 4, so the byte
  // index is simply the low two bits minus two.
  logic [1:0] rx_n, cmd_n;
  logic [7:0] ctrl_w, rd_byte;
  logic       rd_cmd, arg_cmd;

  assign rx_n   = rx_data[1:0] - 2'd2;
  assign cmd_n  = cmd_q[1:0] - 2'd2;
  assign ctrl_w = {3'b000, resp_q, size_q};

  always_comb begin
    rd_byte = 8'h00;
    rd_cmd  = 1'b1;
    if (rx_data >= 8'd2 && rx_data <= 8'd5)        rd_byte = byte_sel(gpi, rx_n);
    else if (rx_data >= 8'd6 && rx_data <= 8'd9)   rd_byte = byte_sel(gpo_q, rx_n);
    else if (rx_data >= 8'd14 && rx_data <= 8'd17) rd_byte = byte_sel(addr_q, rx_n);
    else if (rx_data == 8'd24)                     rd_byte = ctrl_w;
    else                                           rd_cmd  = 1'b0;
  end

  assign arg_cmd = (rx_data >= 8'd10 && rx_data <= 8'd13) ||
                   (rx_data >= 8'd18 && rx_data <= 8'd21) ||
                   (rx_data == 8'd23) || (rx_data == 8'd25);

  always_ff @(posedge clk or posedge m_aresetn) begin
    if (m_aresetn) begin
      state_q    <= S_IDLE;
      cmd_q      <= 8'h00;
      tx_data_q  <= 8'h00;
      gpo_q      <= 32'h0;
      addr_q     <= 32'h0;
      rdata_q    <= 32'h0;
      wdata_q    <= 32'h0;
      size_q     <= 3'd2;
      resp_q     <= 2'd0;
      tx_cnt_q   <= 2'd0;
      tx_idx_q   <= 2'd0;
      wstrb_q    <= 4'h0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rx_ready_q <= 1'b1;
          if (rx_valid && rx_ready_q) begin
            cmd_q <= rx_data;
            if (rd_cmd) begin
              tx_data_q  <= rd_byte;
              tx_valid_q <= 1'b1;
              tx_cnt_q   <= 2'd0;
              rx_ready_q <= 1'b0;
              state_q    <= S_TX;
            end else if (arg_cmd) begin
              state_q <= S_ARG;
            end else if (rx_data == 8'd22) begin
              arvalid_q  <= 1'b1;
              rx_ready_q <= 1'b0;
              state_q    <= S_AR;
            end
          end
        end
        S_ARG: begin
          if (rx_valid && rx_ready_q) begin
            state_q <= S_IDLE;
            if (cmd_q >= 8'd10 && cmd_q <= 8'd13) gpo_q  <= byte_put(gpo_q, cmd_n, rx_data);
            if (cmd_q >= 8'd18 && cmd_q <= 8'd21) addr_q <= byte_put(addr_q, cmd_n, rx_data);
            if (cmd_q == 8'd25) size_q <= rx_data[2:0];
            if (cmd_q == 8'd23) begin
              wdata_q    <= {4{rx_data}};
              wstrb_q    <= strb_for(size_q, addr_q[1:0]);
              awvalid_q  <= 1'b1;
              wvalid_q   <= 1'b1;
              rx_ready_q <= 1'b0;
              state_q    <= S_AW;
            end
          end
        end
        S_TX: begin
          if (tx_ready) begin
            if (tx_cnt_q == 2'd0) begin
              tx_valid_q <= 1'b0;
              rx_ready_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              tx_cnt_q  <= tx_cnt_q - 2'd1;
              tx_idx_q  <= tx_idx_q + 2'd1;
              tx_data_q <= byte_sel(rdata_q, tx_idx_q + 2'd1);
            end
          end
        end
        S_AR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (m_axi_rvalid) begin
            rready_q   <= 1'b0;
            rdata_q    <= m_axi_rdata;
            resp_q     <= m_axi_rresp;
            tx_data_q  <= m_axi_rdata[7:0];
            tx_valid_q <= 1'b1;
            tx_cnt_q   <= 2'd3;
            tx_idx_q   <= 2'd0;
            state_q    <= S_TX;
          end
        end
        S_AW: begin
          // Address and data channels complete independently; leave once both have.
          if (m_axi_awready) awvalid_q <= 1'b0;
          if (m_axi_wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
            bready_q <= 1'b1;
            state_q  <= S_B;
          end
        end
        S_B: begin
          if (m_axi_bvalid) begin
            bready_q   <= 1'b0;
            resp_q     <= m_axi_bresp;
            rx_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_ready      = rx_ready_q;
  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign gpo           = gpo_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_arsize  = size_q;
  assign m_axi_awsize  = size_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_uart_probe.sv
// Bench for uart_probe: drives byte commands and a scripted AXI slave, compares
// against a byte-array model of GPO, address and control state.
module tb_uart_probe;
  logic        clk = 0;
  logic        m_aresetn = 1;
  logic        rx_valid = 0, rx_ready, tx_valid, tx_ready = 0;
  logic [7:0]  rx_data = 0, tx_data;
  logic [31:0] gpo, gpi = 0;
  logic [31:0] m_axi_araddr, m_axi_rdata = 0, m_axi_awaddr, m_axi_wdata;
  logic [2:0]  m_axi_arsize, m_axi_awsize;
  logic        m_axi_arvalid, m_axi_arready = 0, m_axi_rvalid = 0, m_axi_rready;
  logic        m_axi_awvalid, m_axi_awready = 0, m_axi_wvalid, m_axi_wready = 0;
  logic        m_axi_bvalid = 0, m_axi_bready;
  logic [1:0]  m_axi_rresp = 0, m_axi_bresp = 0;
  logic [3:0]  m_axi_wstrb;

  int checks = 0, errors = 0;
  logic [7:0] m_gpo[4];
  logic [7:0] m_addr[4];
  logic [2:0] m_size;
  logic [1:0] m_resp;

  uart_probe dut (
    .clk(clk), .m_aresetn(m_aresetn),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .gpo(gpo), .gpi(gpi),
    .m_axi_araddr(m_axi_araddr), .m_axi_arsize(m_axi_arsize), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awsize(m_axi_awsize), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] addr_word();
    return {m_addr[3], m_addr[2], m_addr[1], m_addr[0]};
  endfunction

  function automatic logic [31:0] gpo_word();
    return {m_gpo[3], m_gpo[2], m_gpo[1], m_gpo[0]};
  endfunction

  function automatic logic [7:0] ctrl_byte();
    return {3'b000, m_resp, m_size};
  endfunction

  // Byte lanes a write of the given size touches at the given address.
  function automatic logic [3:0] exp_strb(input logic [2:0] s, input logic [1:0] a);
    if (s == 3'd0) return 4'(1 << a);
    if (s == 3'd1) return (a >= 2'd2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic sig(input int w);
    case (w)
      0: return tx_valid;
      1: return m_axi_arvalid;
      2: return m_axi_rready;
      3: return m_axi_awvalid;
      default: return m_axi_bready;
    endcase
  endfunction

  task automatic wait_sig(input int w, input string name);
    int n = 0;
    @(negedge clk);
    while (!sig(w) && n < 200) begin @(negedge clk); n++; end
    if (!sig(w)) begin
      checks++; errors++;
      $display("FAIL timeout waiting for %s", name);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_valid = 1; rx_data = b;
    while (!rx_ready && n < 200) begin @(negedge clk); n++; end
    if (!rx_ready) begin
      checks++; errors++;
      $display("FAIL timeout rx_ready for byte %h", b);
    end
    @(posedge clk); #1 rx_valid = 0;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    wait_sig(0, "tx_valid");
    b = tx_data;
    tx_ready = 1;
    @(posedge clk); #1 tx_ready = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_gpo[i] = 0; m_addr[i] = 0; end
    m_size = 3'd2; m_resp = 2'd0;
  endtask

  task automatic test_reset();
    logic [7:0] b;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if ({rx_ready, tx_valid, m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 7'b0) begin
      errors++; $display("FAIL reset_handshakes got %b need 0", {rx_ready, tx_valid, m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready});
    end
    checks++; if (gpo !== 32'h0 || m_axi_araddr !== 32'h0) begin
      errors++; $display("FAIL reset_regs got gpo=%h addr=%h need 0", gpo, m_axi_araddr);
    end
    checks++; if (m_axi_arsize !== 3'd2) begin
      errors++; $display("FAIL reset_size got %0d need 2", m_axi_arsize);
    end
    m_aresetn = 0;
    send_byte(8'd24); recv_byte(b);
    checks++; if (b !== 8'h02) begin errors++; $display("FAIL reset_ctrl got %h need 02", b); end
  endtask

  task automatic test_gpo();
    logic [7:0] b, v;
    int n, k;
    send_byte(8'd10); send_byte(8'hA5); m_gpo[0] = 8'hA5;
    checks++; if (gpo[7:0] !== 8'hA5) begin errors++; $display("FAIL gpo_wr0 got %h need a5", gpo[7:0]); end
    send_byte(8'd6);
    n = 0; @(negedge clk);
    while (!tx_valid && n < 5) begin @(negedge clk); n++; end
    checks++; if (n > 1) begin errors++; $display("FAIL rd_latency got %0d extra cycles need <=1", n); end
    recv_byte(b);
    checks++; if (b !== 8'hA5) begin errors++; $display("FAIL gpo_rd0 got %h need a5", b); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drop got %b need 0", tx_valid); end
    send_byte(8'd13); send_byte(8'h3C); m_gpo[3] = 8'h3C;
    send_byte(8'd9); recv_byte(b);
    checks++; if (b !== 8'h3C || gpo[31:24] !== 8'h3C) begin
      errors++; $display("FAIL gpo_rd3 got tx=%h gpo=%h need 3c", b, gpo[31:24]);
    end
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 3); v = 8'($urandom);
      send_byte(8'(10 + k)); send_byte(v); m_gpo[k] = v;
      k = $urandom_range(0, 3);
      send_byte(8'(6 + k)); recv_byte(b);
      checks++; if (b !== m_gpo[k]) begin errors++; $display("FAIL gpo_rand byte%0d got %h need %h", k, b, m_gpo[k]); end
    end
    checks++; if (gpo !== gpo_word()) begin errors++; $display("FAIL gpo_word got %h need %h", gpo, gpo_word()); end
  endtask

  task automatic test_addr();
    logic [7:0] b, v;
    int k;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 3); v = 8'($urandom);
      send_byte(8'(18 + k)); send_byte(v); m_addr[k] = v;
      send_byte(8'(14 + k)); recv_byte(b);
      checks++; if (b !== v) begin errors++; $display("FAIL addr_rd byte%0d got %h need %h", k, b, v); end
    end
    checks++; if (m_axi_araddr !== addr_word() || m_axi_awaddr !== addr_word()) begin
      errors++; $display("FAIL addr_word got %h/%h need %h", m_axi_araddr, m_axi_awaddr, addr_word());
    end
  endtask

  task automatic test_gpi();
    logic [7:0] b;
    logic [31:0] g;
    gpi = 32'h12345678;
    send_byte(8'd3); recv_byte(b);
    checks++; if (b !== 8'h56) begin errors++; $display("FAIL gpi_rd1 got %h need 56", b); end
    send_byte(8'd5); recv_byte(b);
    checks++; if (b !== 8'h12) begin errors++; $display("FAIL gpi_rd3 got %h need 12", b); end
    for (int i = 0; i < 8; i++) begin
      g = $urandom; gpi = g;
      for (int k = 0; k < 4; k++) begin
        send_byte(8'(2 + k)); recv_byte(b);
        checks++; if (b !== g[8*k +: 8]) begin errors++; $display("FAIL gpi_rand byte%0d got %h need %h", k, b, g[8*k +: 8]); end
      end
    end
  endtask

  task automatic axi_read(input logic [31:0] data, input logic [1:0] resp, input int delay);
    logic [7:0] b;
    send_byte(8'd22);
    wait_sig(1, "arvalid");
    checks++; if (m_axi_araddr !== addr_word() || m_axi_arsize !== m_size) begin
      errors++; $display("FAIL ar_addr got %h/%0d need %h/%0d", m_axi_araddr, m_axi_arsize, addr_word(), m_size);
    end
    repeat (delay) @(negedge clk);
    checks++; if (m_axi_arvalid !== 1'b1 || rx_ready !== 1'b0) begin
      errors++; $display("FAIL ar_hold got arvalid=%b rx_ready=%b need 1/0", m_axi_arvalid, rx_ready);
    end
    m_axi_arready = 1; @(posedge clk); #1 m_axi_arready = 0;
    wait_sig(2, "rready");
    m_axi_rvalid = 1; m_axi_rdata = data; m_axi_rresp = resp;
    @(posedge clk); #1 m_axi_rvalid = 0;
    m_resp = resp;
    for (int k = 0; k < 4; k++) begin
      recv_byte(b);
      checks++; if (b !== data[8*k +: 8]) begin errors++; $display("FAIL rdata byte%0d got %h need %h", k, b, data[8*k +: 8]); end
    end
    send_byte(8'd24); recv_byte(b);
    checks++; if (b !== ctrl_byte()) begin errors++; $display("FAIL rd_ctrl got %h need %h", b, ctrl_byte()); end
  endtask

  task automatic test_axi_read();
    logic [31:0] a = 32'h1000_0004;
    for (int k = 0; k < 4; k++) begin send_byte(8'(18 + k)); send_byte(a[8*k +: 8]); m_addr[k] = a[8*k +: 8]; end
    axi_read(32'hDEADBEEF, 2'd0, 2);
    for (int i = 0; i < 3; i++) axi_read($urandom, 2'($urandom), $urandom_range(0, 4));
  endtask

  task automatic axi_write(input logic [7:0] d, input logic [1:0] resp, input logic split);
    logic [7:0] b;
    send_byte(8'd23); send_byte(d);
    wait_sig(3, "awvalid");
    checks++; if (m_axi_awaddr !== addr_word() || m_axi_awsize !== m_size || m_axi_wvalid !== 1'b1) begin
      errors++; $display("FAIL aw_ctl got %h/%0d/%b need %h/%0d/1", m_axi_awaddr, m_axi_awsize, m_axi_wvalid, addr_word(), m_size);
    end
    checks++; if (m_axi_wdata !== {4{d}} || m_axi_wstrb !== exp_strb(m_size, m_addr[0][1:0])) begin
      errors++; $display("FAIL w_data got %h/%b need %h/%b", m_axi_wdata, m_axi_wstrb, {4{d}}, exp_strb(m_size, m_addr[0][1:0]));
    end
    m_axi_awready = 1; m_axi_wready = !split;
    @(posedge clk); #1 m_axi_awready = 0; m_axi_wready = 0;
    if (split) begin
      @(negedge clk);
      checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b010) begin
        errors++; $display("FAIL aw_split got %b need 010", {m_axi_awvalid, m_axi_wvalid, m_axi_bready});
      end
      m_axi_wready = 1; @(posedge clk); #1 m_axi_wready = 0;
    end
    wait_sig(4, "bready");
    repeat (2) @(negedge clk);
    checks++; if (m_axi_bready !== 1'b1) begin errors++; $display("FAIL b_hold got %b need 1", m_axi_bready); end
    m_axi_bvalid = 1; m_axi_bresp = resp;
    @(posedge clk); #1 m_axi_bvalid = 0;
    m_resp = resp;
    @(negedge clk);
    checks++; if (m_axi_bready !== 1'b0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL b_done got bready=%b tx_valid=%b need 0/0", m_axi_bready, tx_valid);
    end
    send_byte(8'd24); recv_byte(b);
    checks++; if (b !== ctrl_byte()) begin errors++; $display("FAIL wr_ctrl got %h need %h", b, ctrl_byte()); end
  endtask

  task automatic test_axi_write();
    logic [7:0] v;
    send_byte(8'd18); send_byte(8'h06); m_addr[0] = 8'h06;
    send_byte(8'd25); send_byte(8'h00); m_size = 3'd0;
    axi_write(8'h77, 2'd2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom);
      send_byte(8'd18); send_byte(v); m_addr[0] = v;
      v = 8'($urandom);
      send_byte(8'd25); send_byte(v); m_size = v[2:0];
      axi_write(8'($urandom), 2'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_robustness();
    logic [7:0] b, held;
    send_byte(8'h00);
    send_byte(8'($urandom_range(26, 255)));
    repeat (4) @(negedge clk);
    checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL unknown_cmd got tx_valid=%b rx_ready=%b need 0/1", tx_valid, rx_ready);
    end
    send_byte(8'd6); recv_byte(b);
    checks++; if (b !== m_gpo[0]) begin errors++; $display("FAIL after_unknown got %h need %h", b, m_gpo[0]); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL extra_tx got %b need 0", tx_valid); end
    send_byte(8'd7);
    wait_sig(0, "tx_valid");
    held = tx_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (tx_valid !== 1'b1 || tx_data !== held) begin
        errors++; $display("FAIL tx_stall cyc%0d got %b/%h need 1/%h", i, tx_valid, tx_data, held);
      end
    end
    recv_byte(b);
    checks++; if (b !== m_gpo[1]) begin errors++; $display("FAIL stall_byte got %h need %h", b, m_gpo[1]); end
  endtask

  task automatic test_reset_mid_ar();
    logic [7:0] b;
    send_byte(8'd10); send_byte(8'h5A);
    send_byte(8'd19); send_byte(8'hC3);
    send_byte(8'd22);
    wait_sig(1, "arvalid");
    m_aresetn = 1;
    #1;
    checks++; if (m_axi_arvalid !== 1'b0 || gpo !== 32'h0 || m_axi_araddr !== 32'h0 || rx_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ar got arvalid=%b gpo=%h addr=%h rx_ready=%b need 0", m_axi_arvalid, gpo, m_axi_araddr, rx_ready);
    end
    model_reset();
    @(negedge clk); m_aresetn = 0;
    send_byte(8'd24); recv_byte(b);
    checks++; if (b !== ctrl_byte()) begin errors++; $display("FAIL post_reset_ctrl got %h need %h", b, ctrl_byte()); end
    send_byte(8'd15); recv_byte(b);
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL post_reset_addr got %h need 00", b); end
  endtask

  initial begin
    test_reset();
    test_gpo();
    test_addr();
    test_gpi();
    test_axi_read();
    test_axi_write();
    test_robustness();
    test_reset_mid_ar();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
